axi_grid_rd_tni: RTL and testbench

AXI_GRID_RD_TNI -- requirements
Module: axi_grid_rd_tni

---
 rtl/axi_default_param_pkg.sv | 35 +++
 rtl/axi_grid_rd_tni.sv | 139 +++++++++++++
 tb/tb_axi_grid_rd_tni.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_default_param_pkg.sv
// Default grid/AXI read channel types for the grid read target interface.
// Four-bit node ids, four-bit AXI ids, 32-bit address and data.
package axi_default_param_pkg;

    typedef logic [3:0] grid_id_t;
    typedef logic [3:0] axi_id_t;

    typedef struct packed {
        axi_id_t     id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        axi_id_t     id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        grid_id_t src;
        grid_id_t dst;
        ar_chan_t ar;
    } grid_ar_chan_t;

    typedef struct packed {
        grid_id_t src;
        grid_id_t dst;
        r_chan_t  r;
    } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_rd_tni.sv
// Grid-to-AXI read target interface: remaps AXI ids to tag slots that
// remember the requester, and routes read data back to it.
module axi_grid_rd_tni #(
    parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
    parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
    parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
    parameter type ar_chan_t      = axi_default_param_pkg::ar_chan_t,
    parameter type r_chan_t       = axi_default_param_pkg::r_chan_t,
    parameter type axi_id_t       = axi_default_param_pkg::axi_id_t,
    parameter grid_id_t    NI_ID           = '0,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned SW = $clog2(MAX_OUTSTANDING)
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  grid_ar_chan_t grid_ar_i,
    input  logic          grid_ar_valid_i,
    output logic          grid_ar_ready_o,
    output grid_r_chan_t  grid_r_o,
    output logic          grid_r_valid_o,
    input  logic          grid_r_ready_i,
    output ar_chan_t      axi_ar_o,
    output logic          axi_ar_valid_o,
    input  logic          axi_ar_ready_i,
    input  r_chan_t       axi_r_i,
    input  logic          axi_r_valid_i,
    output logic          axi_r_ready_o,
    output logic [SW:0]   outstanding_o,
    output logic          err_o
);

    logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
    grid_id_t                   src_q  [MAX_OUTSTANDING];
    grid_id_t                   src_d  [MAX_OUTSTANDING];
    axi_id_t                    orig_q [MAX_OUTSTANDING];
    axi_id_t                    orig_d [MAX_OUTSTANDING];
    logic [SW:0]                cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic          free_any;
    logic [SW-1:0] free_idx;
    logic [SW-1:0] slot;
    logic          hit;
    grid_id_t      slot_src;
    axi_id_t       slot_orig;
    logic          dst_ok;
    logic          alloc;
    logic          r_hs;
    logic          rel;

    // Lowest-index free slot; only registered busy bits are considered, so a
    // slot being released this cycle is never handed out in the same cycle.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    always_comb begin
        slot      = axi_r_i.id[SW-1:0];
        hit       = 1'b0;
        slot_src  = '0;
        slot_orig = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (slot == SW'(i)) begin
                hit       = busy_q[i];
                slot_src  = src_q[i];
                slot_orig = orig_q[i];
            end
        end
    end

    always_comb begin
        dst_ok          = (grid_ar_i.dst == NI_ID);
        axi_ar_valid_o  = grid_ar_valid_i & dst_ok & free_any;
        grid_ar_ready_o = dst_ok ? (free_any & axi_ar_ready_i) : 1'b1;
        axi_ar_o        = grid_ar_i.ar;
        axi_ar_o.id     = axi_id_t'(free_idx);

        grid_r_valid_o  = axi_r_valid_i;
        axi_r_ready_o   = grid_r_ready_i;
        grid_r_o        = '0;
        grid_r_o.src    = NI_ID;
        grid_r_o.dst    = hit ? slot_src : '0;
        grid_r_o.r      = axi_r_i;
        grid_r_o.r.id   = hit ? slot_orig : '0;
    end

    always_comb begin
        alloc  = axi_ar_valid_o & axi_ar_ready_i;
        r_hs   = axi_r_valid_i & grid_r_ready_i;
        rel    = r_hs & axi_r_i.last & hit;
        busy_d = busy_q;
        src_d  = src_q;
        orig_d = orig_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (rel && slot == SW'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (alloc && free_idx == SW'(i)) begin
                busy_d[i] = 1'b1;
                src_d[i]  = grid_ar_i.src;
                orig_d[i] = grid_ar_i.ar.id;
            end
        end
        cnt_d = cnt_q + (SW+1)'(alloc) - (SW+1)'(rel);
        // Misrouted requests and beats for idle slots are both reported.
        err_d = (grid_ar_valid_i & ~dst_ok) | (r_hs & ~hit);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                src_q[i]  <= '0;
                orig_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                src_q[i]  <= src_d[i];
                orig_q[i] <= orig_d[i];
            end
        end
    end

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_axi_grid_rd_tni.sv
// Directed and random bench for axi_grid_rd_tni against a slot-table model.
// NI_ID = 3, four slots.
module tb_axi_grid_rd_tni;
    import axi_default_param_pkg::*;

    localparam grid_id_t NI = 4'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    grid_ar_chan_t gar;
    logic          gar_v, gar_rdy;
    grid_r_chan_t  gr;
    logic          gr_v, gr_rdy;
    ar_chan_t      aar;
    logic          aar_v, aar_rdy;
    r_chan_t       ar_r;
    logic          ar_r_v, ar_r_rdy;
    logic [2:0]    outst;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic     busy_m [4];
    grid_id_t src_m  [4];
    axi_id_t  orig_m [4];

    always #5 clk = ~clk;

    axi_grid_rd_tni #(
        .NI_ID           (NI),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i           (clk),
        .arst_ni         (rst_n),
        .grid_ar_i       (gar),
        .grid_ar_valid_i (gar_v),
        .grid_ar_ready_o (gar_rdy),
        .grid_r_o        (gr),
        .grid_r_valid_o  (gr_v),
        .grid_r_ready_i  (gr_rdy),
        .axi_ar_o        (aar),
        .axi_ar_valid_o  (aar_v),
        .axi_ar_ready_i  (aar_rdy),
        .axi_r_i         (ar_r),
        .axi_r_valid_i   (ar_r_v),
        .axi_r_ready_o   (ar_r_rdy),
        .outstanding_o   (outst),
        .err_o           (err)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_m();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(busy_m[i]);
        return n;
    endfunction

    function automatic int lowest_m();
        for (int i = 0; i < 4; i++) if (!busy_m[i]) return i;
        return -1;
    endfunction

    task automatic clear_m();
        for (int i = 0; i < 4; i++) begin
            busy_m[i] = 1'b0;
            src_m[i]  = '0;
            orig_m[i] = '0;
        end
    endtask

    // One clock: check combinational outputs against the slot table,
    // advance the table by the handshakes seen, then check registered outputs.
    task automatic tick();
        bit           dst_ok, has_free, hit, alloc, mis, rhs, exp_err;
        int           lf, rs;
        ar_chan_t     ear;
        r_chan_t      er;
        grid_r_chan_t egr;
        #1;
        dst_ok   = (gar.dst == NI);
        lf       = lowest_m();
        has_free = (lf >= 0);
        chk("ar_valid", 64'(aar_v), 64'(gar_v && dst_ok && has_free));
        chk("ar_ready", 64'(gar_rdy),
            64'(dst_ok ? (has_free && aar_rdy) : 1'b1));
        if (gar_v && dst_ok && has_free) begin
            ear    = gar.ar;
            ear.id = axi_id_t'(lf);
            chk("ar_out", 64'(aar), 64'(ear));
        end
        rs      = int'(ar_r.id[1:0]);
        hit     = busy_m[rs];
        er      = ar_r;
        er.id   = hit ? orig_m[rs] : '0;
        egr.src = NI;
        egr.dst = hit ? src_m[rs] : '0;
        egr.r   = er;
        if (ar_r_v) chk("r_out", 64'(gr), 64'(egr));
        chk("r_valid", 64'(gr_v), 64'(ar_r_v));
        chk("r_ready", 64'(ar_r_rdy), 64'(gr_rdy));
        alloc   = gar_v && dst_ok && has_free && aar_rdy;
        mis     = gar_v && !dst_ok;
        rhs     = ar_r_v && gr_rdy;
        exp_err = mis || (rhs && !hit);
        @(posedge clk);
        if (rhs && hit && ar_r.last) busy_m[rs] = 1'b0;
        if (alloc) begin
            busy_m[lf] = 1'b1;
            src_m[lf]  = gar.src;
            orig_m[lf] = gar.ar.id;
        end
        #1;
        chk("err", 64'(err), 64'(exp_err));
        chk("outstanding", 64'(outst), 64'(count_m()));
    endtask

    task automatic set_ar(input grid_id_t s, input grid_id_t d,
                          input axi_id_t i);
        gar.src      = s;
        gar.dst      = d;
        gar.ar.id    = i;
        gar.ar.addr  = 32'($urandom);
        gar.ar.len   = 8'd1;
        gar.ar.size  = 3'd2;
        gar.ar.burst = 2'd1;
        gar_v        = 1'b1;
        aar_rdy      = 1'b1;
    endtask

    task automatic set_r(input axi_id_t i, input logic l);
        ar_r.id   = i;
        ar_r.data = 32'($urandom);
        ar_r.resp = 2'd0;
        ar_r.last = l;
        ar_r_v    = 1'b1;
        gr_rdy    = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        gar     = '0;
        gar_v   = 1'b0;
        gr_rdy  = 1'b0;
        aar_rdy = 1'b0;
        ar_r    = '0;
        ar_r_v  = 1'b0;
        clear_m();
        #2;
        chk("rst_outstanding", 64'(outst), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // single read, two beats
        set_ar(4'd5, NI, 4'd7);
        #1;
        chk("single_ar_id", 64'(aar.id), 64'd0);
        tick();
        gar_v = 1'b0;
        chk("single_out1", 64'(outst), 64'd1);
        set_r(4'd0, 1'b0);
        #1;
        chk("single_dst", 64'(gr.dst), 64'd5);
        chk("single_src", 64'(gr.src), 64'd3);
        chk("single_id", 64'(gr.r.id), 64'd7);
        tick();
        chk("single_mid", 64'(outst), 64'd1);
        set_r(4'd0, 1'b1);
        tick();
        ar_r_v = 1'b0;
        chk("single_out0", 64'(outst), 64'd0);

        // fill all slots, fifth waits for slot 2 to retire
        for (int i = 0; i < 4; i++) begin
            set_ar(grid_id_t'(i + 1), NI, axi_id_t'(i + 8));
            #1;
            chk("fill_id", 64'(aar.id), 64'(i));
            tick();
        end
        chk("fill_full", 64'(outst), 64'd4);
        set_ar(4'd9, NI, 4'd1);
        #1;
        chk("full_ready", 64'(gar_rdy), 64'd0);
        chk("full_valid", 64'(aar_v), 64'd0);
        tick();
        set_r(4'd2, 1'b1);
        #1;
        chk("full_ready2", 64'(gar_rdy), 64'd0);
        tick();
        ar_r_v = 1'b0;
        #1;
        chk("reuse_ready", 64'(gar_rdy), 64'd1);
        chk("reuse_id", 64'(aar.id), 64'd2);
        tick();
        gar_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_r(axi_id_t'(i), 1'b1);
            tick();
        end
        ar_r_v = 1'b0;

        // AR held under slave backpressure stays stable
        set_ar(4'd6, NI, 4'd3);
        aar_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", 64'(aar_v), 64'd1);
            chk("stall_id", 64'(aar.id), 64'd0);
            tick();
        end
        aar_rdy = 1'b1;
        tick();
        gar_v = 1'b0;
        set_r(4'd0, 1'b1);
        tick();
        ar_r_v = 1'b0;

        // out-of-order return
        set_ar(4'd1, NI, 4'd9);
        tick();
        set_ar(4'd2, NI, 4'd10);
        tick();
        gar_v = 1'b0;
        set_r(4'd1, 1'b1);
        #1;
        chk("ooo_dst_a", 64'(gr.dst), 64'd2);
        chk("ooo_id_a", 64'(gr.r.id), 64'd10);
        tick();
        set_r(4'd0, 1'b1);
        #1;
        chk("ooo_dst_b", 64'(gr.dst), 64'd1);
        chk("ooo_id_b", 64'(gr.r.id), 64'd9);
        tick();
        ar_r_v = 1'b0;

        // misrouted request
        set_ar(4'd7, 4'd4, 4'd1);
        #1;
        chk("mis_ready", 64'(gar_rdy), 64'd1);
        chk("mis_valid", 64'(aar_v), 64'd0);
        tick();
        gar_v = 1'b0;
        chk("mis_err1", 64'(err), 64'd1);
        tick();
        chk("mis_err0", 64'(err), 64'd0);

        // response backpressure, then reset with slots busy
        set_ar(4'd1, NI, 4'd2);
        tick();
        set_ar(4'd2, NI, 4'd3);
        tick();
        gar_v = 1'b0;
        set_r(4'd0, 1'b1);
        gr_rdy = 1'b0;
        #1;
        chk("bp_ready", 64'(ar_r_rdy), 64'd0);
        tick();
        chk("bp_busy", 64'(outst), 64'd2);
        ar_r_v = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("arst_out", 64'(outst), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        clear_m();
        rst_n = 1'b1;
        set_r(4'd0, 1'b1);
        #1;
        chk("stale_dst", 64'(gr.dst), 64'd0);
        chk("stale_id", 64'(gr.r.id), 64'd0);
        tick();
        chk("stale_err", 64'(err), 64'd1);
        ar_r_v = 1'b0;
        tick();
        chk("stale_err0", 64'(err), 64'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            gar.src      = grid_id_t'($urandom);
            gar.dst      = ($urandom_range(0, 5) == 0) ? 4'd4 : NI;
            gar.ar.id    = axi_id_t'($urandom);
            gar.ar.addr  = 32'($urandom);
            gar.ar.len   = 8'($urandom);
            gar.ar.size  = 3'($urandom);
            gar.ar.burst = 2'($urandom);
            gar_v        = 1'($urandom_range(0, 1));
            aar_rdy      = ($urandom_range(0, 3) != 0);
            ar_r.id      = axi_id_t'($urandom);
            ar_r.data    = 32'($urandom);
            ar_r.resp    = 2'($urandom);
            ar_r.last    = ($urandom_range(0, 2) == 0);
            ar_r_v       = 1'($urandom_range(0, 1));
            gr_rdy       = 1'($urandom_range(0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
